gpu_microsequencer: RTL and testbench

- Issues the microcode stream that feeds the GPU microcode decoder; it is the producer of `current_microcode`.
- Accepts an opcode and repeat count from the command front-end, then fetches microinstructions from an external synchronous microcode ROM.
- Presents each microinstruction for exactly one cycle, or holds it while a WAIT_* condition is unmet.
- Implements the REPEAT_UCODE and CONTINUE_OR_END looping and ENDMICRO termination, then signals completion.

---
 rtl/gpu_microsequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_gpu_microsequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_microsequencer.sv
// ---------------------------------------------------------------------------
// gpu_microsequencer
//
// Produces the microcode stream consumed by the GPU microcode decoder.
// The command front-end hands over an opcode and a repeat count. The
// sequencer then walks that opcode's 16-entry slot in an external
// synchronous microcode ROM. Each fetched microinstruction is presented on
// current_microcode for exactly one cycle, or held while its WAIT_*
// condition is unmet. REPEAT_UCODE and CONTINUE_OR_END loop on the repeat
// counter. ENDMICRO retires the opcode.
//
// Optional build macro: GPU_USEQ_PREFETCH_EN
//   When defined, plain sequential microinstructions prefetch the next ROM
//   word while they execute, so they issue one per cycle instead of one
//   every two cycles.
//
// Ports
//   clk, n_reset        clock, asynchronous active-low reset
//   op_valid/op_ready   opcode handshake (ready only in IDLE)
//   op_code, op_rep     opcode (selects the ROM slot) and repeat count
//   op_done             one-cycle pulse when the opcode retires normally
//   busy                high whenever the sequencer is not IDLE
//   err                 sticky slot-overrun flag, cleared only by reset
//   rep_cnt             live repeat counter
//   urom_addr/urom_rd   ROM read address and read strobe
//   urom_data           ROM word, valid the cycle after urom_rd, then held
//   current_microcode   microinstruction presented to the decoder
//   mau_all_idle, mau_any_idle, fb_busy, ldu_busy, start_req, dtcu_busy
//                       wait conditions for the WAIT_* microinstructions
// ---------------------------------------------------------------------------

package gpu_microsequencer_pkg;

  typedef enum logic [4:0] {
    WAIT_CYCLE      = 5'd0,
    ENDMICRO        = 5'd1,
    REPEAT_UCODE    = 5'd2,
    CONTINUE_OR_END = 5'd3,
    WAIT_ALL_MAU    = 5'd4,
    WAIT_ANY_MAU    = 5'd5,
    WAIT_FB         = 5'd6,
    WAIT_LDU        = 5'd7,
    WAIT_START      = 5'd8,
    WAIT_DTCU       = 5'd9,
    INC_PC_A        = 5'd10,
    INC_PC_B        = 5'd11,
    SEND_FRAME      = 5'd12,
    DRAW_PIXEL      = 5'd13,
    LOAD_COORD      = 5'd14,
    STORE_RESULT    = 5'd15
  } GPU_Microcode_enum;

endpackage

module gpu_microsequencer
  import gpu_microsequencer_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int SLOT_W  = 4,
  parameter int REP_W   = 16,
  parameter int UADDR_W = OP_W + SLOT_W
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [OP_W-1:0]    op_code,
  input  logic [REP_W-1:0]   op_rep,
  output logic               op_done,
  output logic               busy,
  output logic               err,
  output logic [REP_W-1:0]   rep_cnt,
  output logic [UADDR_W-1:0] urom_addr,
  output logic               urom_rd,
  input  GPU_Microcode_enum  urom_data,
  output GPU_Microcode_enum  current_microcode,
  input  logic               mau_all_idle,
  input  logic               mau_any_idle,
  input  logic               fb_busy,
  input  logic               ldu_busy,
  input  logic               start_req,
  input  logic               dtcu_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               err_q, err_d;

  logic               code_stall;
  logic               slot_end;
  logic [UADDR_W-1:0] upc_inc;
  logic [UADDR_W-1:0] slot_entry;

  // A WAIT_* code stalls while its condition is unmet. Every other code
  // never stalls.
  function automatic logic stall_of(input GPU_Microcode_enum code,
                                    input logic all_idle,
                                    input logic any_idle,
                                    input logic fb,
                                    input logic ldu,
                                    input logic start,
                                    input logic dtcu);
    logic s;
    s = 1'b0;
    case (code)
      WAIT_ALL_MAU: s = !all_idle;
      WAIT_ANY_MAU: s = !any_idle;
      WAIT_FB:      s = fb;
      WAIT_LDU:     s = ldu;
      WAIT_START:   s = !start;
      WAIT_DTCU:    s = dtcu;
      default:      s = 1'b0;
    endcase
    return s;
  endfunction

`ifdef GPU_USEQ_PREFETCH_EN
  // WAIT_* codes always leave through FETCH, so a stall release re-reads
  // the ROM instead of relying on a prefetch.
  function automatic logic is_wait_code(input GPU_Microcode_enum code);
    logic w;
    w = 1'b0;
    case (code)
      WAIT_ALL_MAU, WAIT_ANY_MAU, WAIT_FB,
      WAIT_LDU, WAIT_START, WAIT_DTCU: w = 1'b1;
      default:                         w = 1'b0;
    endcase
    return w;
  endfunction
`endif

  assign code_stall = stall_of(urom_data, mau_all_idle, mau_any_idle,
                               fb_busy, ldu_busy, start_req, dtcu_busy);
  assign slot_end   = &upc_q[SLOT_W-1:0];
  assign upc_inc    = upc_q + UADDR_W'(1);
  assign slot_entry = {upc_q[UADDR_W-1:SLOT_W], {SLOT_W{1'b0}}};

  assign op_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign rep_cnt  = rep_q;

  // ---- state register ------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      upc_q   <= '0;
      rep_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  // ---- next state and outputs ---------------------------------------------
  always_comb begin
    state_d           = state_q;
    upc_d             = upc_q;
    rep_d             = rep_q;
    err_d             = err_q;
    urom_addr         = upc_q;
    urom_rd           = 1'b0;
    op_done           = 1'b0;
    current_microcode = WAIT_CYCLE;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          upc_d   = {op_code, {SLOT_W{1'b0}}};
          rep_d   = op_rep;
          state_d = FETCH;
        end
      end

      FETCH: begin
        urom_rd = 1'b1;
        state_d = EXEC;
      end

      EXEC: begin
        current_microcode = urom_data;
        // While stalled, nothing advances and the ROM keeps its word
        // because urom_rd stays low.
        if (!code_stall) begin
          case (urom_data)
            ENDMICRO: begin
              op_done = 1'b1;
              state_d = IDLE;
            end

            REPEAT_UCODE: begin
              if (rep_q != '0) begin
                rep_d = rep_q - REP_W'(1);
                upc_d = slot_entry;
              end else begin
                upc_d = upc_inc;
              end
              state_d = FETCH;
            end

            CONTINUE_OR_END: begin
              if (rep_q != '0) begin
                rep_d   = rep_q - REP_W'(1);
                upc_d   = upc_inc;
                state_d = FETCH;
              end else begin
                op_done = 1'b1;
                state_d = IDLE;
              end
            end

            default: begin
              if (slot_end) begin
                // The microprogram ran off the end of its slot. Abandon it
                // without op_done and flag the error.
                err_d   = 1'b1;
                state_d = IDLE;
              end else begin
                upc_d   = upc_inc;
                state_d = FETCH;
`ifdef GPU_USEQ_PREFETCH_EN
                if (!is_wait_code(urom_data)) begin
                  urom_addr = upc_inc;
                  urom_rd   = 1'b1;
                  state_d   = EXEC;
                end
`endif
              end
            end
          endcase
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gpu_microsequencer.sv
`timescale 1ns/1ps
module tb_gpu_microsequencer;
  import gpu_microsequencer_pkg::*;

  localparam int OP_W    = 6;
  localparam int SLOT_W  = 4;
  localparam int REP_W   = 16;
  localparam int UADDR_W = OP_W + SLOT_W;

  logic               clk;
  logic               n_reset;
  logic               op_valid;
  logic               op_ready;
  logic [OP_W-1:0]    op_code;
  logic [REP_W-1:0]   op_rep;
  logic               op_done;
  logic               busy;
  logic               err;
  logic [REP_W-1:0]   rep_cnt;
  logic [UADDR_W-1:0] urom_addr;
  logic               urom_rd;
  GPU_Microcode_enum  urom_data;
  GPU_Microcode_enum  current_microcode;
  logic               mau_all_idle;
  logic               mau_any_idle;
  logic               fb_busy;
  logic               ldu_busy;
  logic               start_req;
  logic               dtcu_busy;

  GPU_Microcode_enum  rom [0:(1<<UADDR_W)-1];

  int checks = 0;
  int errors = 0;

  gpu_microsequencer #(
    .OP_W(OP_W), .SLOT_W(SLOT_W), .REP_W(REP_W), .UADDR_W(UADDR_W)
  ) dut (
    .clk(clk), .n_reset(n_reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_rep(op_rep),
    .op_done(op_done), .busy(busy), .err(err), .rep_cnt(rep_cnt),
    .urom_addr(urom_addr), .urom_rd(urom_rd), .urom_data(urom_data),
    .current_microcode(current_microcode),
    .mau_all_idle(mau_all_idle), .mau_any_idle(mau_any_idle),
    .fb_busy(fb_busy), .ldu_busy(ldu_busy),
    .start_req(start_req), .dtcu_busy(dtcu_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: word appears the cycle after the read and is then held
  always @(posedge clk) begin
    if (urom_rd) urom_data <= rom[urom_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Returns at the sample point of the first cycle after the accept edge.
  task automatic start_op(input logic [OP_W-1:0] code, input logic [REP_W-1:0] rep);
    int n;
    n = 0;
    while (op_ready !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: op_ready=%b required 1", op_ready);
    end
    op_code  = code;
    op_rep   = rep;
    op_valid = 1'b1;
    cyc();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (3) cyc();
    checks += 8;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_op_ready: got %b required 1", op_ready); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (err !== 1'b0)      begin errors++; $display("FAIL rst_err: got %b required 0", err); end
    if (op_done !== 1'b0)  begin errors++; $display("FAIL rst_op_done: got %b required 0", op_done); end
    if (rep_cnt !== '0)    begin errors++; $display("FAIL rst_rep_cnt: got %0d required 0", rep_cnt); end
    if (urom_rd !== 1'b0)  begin errors++; $display("FAIL rst_urom_rd: got %b required 0", urom_rd); end
    if (urom_addr !== '0)  begin errors++; $display("FAIL rst_urom_addr: got %0d required 0", urom_addr); end
    if (current_microcode !== WAIT_CYCLE) begin errors++; $display("FAIL rst_code: got %0d required %0d", current_microcode, WAIT_CYCLE); end
    n_reset = 1'b1;
    cyc();
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", op_ready); end
  endtask

  task automatic test_straight();
    GPU_Microcode_enum exp_cm   [1:7];
    logic              exp_rd   [1:7];
    int                exp_addr [1:7];
    logic              exp_done [1:7];
    logic              exp_busy [1:7];
    rom[48] = INC_PC_A;
    rom[49] = SEND_FRAME;
    rom[50] = ENDMICRO;
    rom[51] = DRAW_PIXEL;
`ifndef GPU_USEQ_PREFETCH_EN
    exp_cm   = '{WAIT_CYCLE, INC_PC_A, WAIT_CYCLE, SEND_FRAME, WAIT_CYCLE, ENDMICRO, WAIT_CYCLE};
    exp_rd   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_addr = '{48, 0, 49, 0, 50, 0, 0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_cm   = '{WAIT_CYCLE, INC_PC_A, SEND_FRAME, ENDMICRO, WAIT_CYCLE, WAIT_CYCLE, WAIT_CYCLE};
    exp_rd   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_addr = '{48, 49, 50, 0, 0, 0, 0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    start_op(6'd3, 16'd0);
    for (int c = 1; c <= 7; c++) begin
      checks += 4;
      if (current_microcode !== exp_cm[c]) begin errors++; $display("FAIL straight_code c%0d: got %0d required %0d", c, current_microcode, exp_cm[c]); end
      if (urom_rd !== exp_rd[c])           begin errors++; $display("FAIL straight_rd c%0d: got %b required %b", c, urom_rd, exp_rd[c]); end
      if (op_done !== exp_done[c])         begin errors++; $display("FAIL straight_done c%0d: got %b required %b", c, op_done, exp_done[c]); end
      if (busy !== exp_busy[c])            begin errors++; $display("FAIL straight_busy c%0d: got %b required %b", c, busy, exp_busy[c]); end
      if (exp_rd[c]) begin
        checks++;
        if (int'(urom_addr) !== exp_addr[c]) begin errors++; $display("FAIL straight_addr c%0d: got %0d required %0d", c, urom_addr, exp_addr[c]); end
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    int bad_rd, done_cnt, n;
    bad_rd = 0; done_cnt = 0; n = 0;
    start_op(6'd3, 16'd0);
    // A request arriving while busy must be ignored.
    op_code  = 6'd4;
    op_valid = 1'b1;
    while (busy && n < 30) begin
      if (urom_rd && (urom_addr < 48 || urom_addr > 50)) bad_rd++;
      if (op_done) done_cnt++;
      if (n == 1) op_valid = 1'b0;
      cyc();
      n++;
    end
    op_valid = 1'b0;
    checks += 3;
    if (bad_rd !== 0)   begin errors++; $display("FAIL b2b_ignore: stray reads %0d required 0", bad_rd); end
    if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done1: got %0d required 1", done_cnt); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL b2b_idle1: busy=%b required 0", busy); end
    // Second opcode right away
    start_op(6'd3, 16'd0);
    checks++;
    if (urom_rd !== 1'b1 || urom_addr !== 10'd48) begin errors++; $display("FAIL b2b_entry: rd=%b addr=%0d required 1/48", urom_rd, urom_addr); end
    done_cnt = 0; n = 0;
    while (busy && n < 30) begin
      if (op_done) done_cnt++;
      cyc();
      n++;
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done2: got %0d required 1", done_cnt); end
  endtask

  task automatic test_stall();
    int held, wait_total, fetch65, done_cnt, n;
    bit released;
    held = 0; wait_total = 0; fetch65 = 0; done_cnt = 0; n = 0; released = 0;
    rom[64] = WAIT_FB;
    rom[65] = ENDMICRO;
    fb_busy = 1'b1;
    start_op(6'd4, 16'd0);
    while (busy && n < 40) begin
      if (current_microcode == WAIT_FB) wait_total++;
      if (urom_rd && urom_addr == 10'd65) fetch65++;
      if (op_done) done_cnt++;
      if (current_microcode == WAIT_FB && !released) begin
        held++;
        checks++;
        if (urom_rd !== 1'b0 || urom_addr !== 10'd64) begin
          errors++;
          $display("FAIL stall_hold %0d: rd=%b addr=%0d required 0/64", held, urom_rd, urom_addr);
        end
        if (held == 5) begin
          fb_busy  = 1'b0;
          released = 1;
        end
      end
      cyc();
      n++;
    end
    fb_busy = 1'b0;
    checks += 5;
    if (held !== 5)       begin errors++; $display("FAIL stall_held: got %0d required 5", held); end
    if (wait_total !== 5) begin errors++; $display("FAIL stall_total: WAIT_FB cycles %0d required 5", wait_total); end
    if (fetch65 !== 1)    begin errors++; $display("FAIL stall_advance: reads of 65 %0d required 1", fetch65); end
    if (done_cnt !== 1)   begin errors++; $display("FAIL stall_done: got %0d required 1", done_cnt); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL stall_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_repeat();
    int draws, done_cnt, n;
    int draw_rep [0:2];
    draws = 0; done_cnt = 0; n = 0;
    draw_rep = '{-1, -1, -1};
    rom[96] = DRAW_PIXEL;
    rom[97] = REPEAT_UCODE;
    rom[98] = ENDMICRO;
    start_op(6'd6, 16'd2);
    checks++;
    if (rep_cnt !== 16'd2) begin errors++; $display("FAIL rep_latch: got %0d required 2", rep_cnt); end
    while (busy && n < 60) begin
      if (current_microcode == DRAW_PIXEL) begin
        if (draws < 3) draw_rep[draws] = int'(rep_cnt);
        draws++;
      end
      if (op_done) done_cnt++;
      cyc();
      n++;
    end
    checks += 6;
    if (draws !== 3)       begin errors++; $display("FAIL rep_draws: got %0d required 3", draws); end
    if (draw_rep[0] !== 2) begin errors++; $display("FAIL rep_cnt0: got %0d required 2", draw_rep[0]); end
    if (draw_rep[1] !== 1) begin errors++; $display("FAIL rep_cnt1: got %0d required 1", draw_rep[1]); end
    if (draw_rep[2] !== 0) begin errors++; $display("FAIL rep_cnt2: got %0d required 0", draw_rep[2]); end
    if (done_cnt !== 1)    begin errors++; $display("FAIL rep_done: got %0d required 1", done_cnt); end
    if (rep_cnt !== '0)    begin errors++; $display("FAIL rep_final: got %0d required 0", rep_cnt); end
  endtask

  task automatic test_continue();
    int read113, sends, done_cnt, n;
    GPU_Microcode_enum done_code;
    rom[112] = CONTINUE_OR_END;
    rom[113] = SEND_FRAME;
    rom[114] = ENDMICRO;
    for (int pass = 0; pass < 2; pass++) begin
      read113 = 0; sends = 0; done_cnt = 0; n = 0; done_code = WAIT_CYCLE;
      start_op(6'd7, REP_W'(pass));
      while (busy && n < 40) begin
        if (urom_rd && urom_addr == 10'd113) read113++;
        if (current_microcode == SEND_FRAME) sends++;
        if (op_done) begin
          done_cnt++;
          done_code = current_microcode;
        end
        cyc();
        n++;
      end
      checks += 4;
      if (done_cnt !== 1) begin errors++; $display("FAIL cont%0d_done: got %0d required 1", pass, done_cnt); end
      if (pass == 0) begin
        if (done_code !== CONTINUE_OR_END) begin errors++; $display("FAIL cont0_end_code: got %0d required %0d", done_code, CONTINUE_OR_END); end
        if (read113 !== 0) begin errors++; $display("FAIL cont0_no_read: reads %0d required 0", read113); end
        if (sends !== 0)   begin errors++; $display("FAIL cont0_sends: got %0d required 0", sends); end
      end else begin
        if (done_code !== ENDMICRO) begin errors++; $display("FAIL cont1_end_code: got %0d required %0d", done_code, ENDMICRO); end
        if (sends !== 1)   begin errors++; $display("FAIL cont1_sends: got %0d required 1", sends); end
        if (rep_cnt !== '0) begin errors++; $display("FAIL cont1_rep: got %0d required 0", rep_cnt); end
      end
    end
  endtask

  task automatic test_overrun();
    int incs, done_cnt, read160, n;
    incs = 0; done_cnt = 0; read160 = 0; n = 0;
    for (int i = 144; i < 160; i++) rom[i] = INC_PC_A;
    rom[160] = ENDMICRO;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL ovr_pre_err: got %b required 0", err); end
    start_op(6'd9, 16'd0);
    while (busy && n < 80) begin
      if (current_microcode == INC_PC_A) incs++;
      if (op_done) done_cnt++;
      if (urom_rd && urom_addr == 10'd160) read160++;
      cyc();
      n++;
    end
    checks += 5;
    if (incs !== 16)       begin errors++; $display("FAIL ovr_count: got %0d required 16", incs); end
    if (done_cnt !== 0)    begin errors++; $display("FAIL ovr_no_done: got %0d required 0", done_cnt); end
    if (err !== 1'b1)      begin errors++; $display("FAIL ovr_err: got %b required 1", err); end
    if (read160 !== 0)     begin errors++; $display("FAIL ovr_no_read: reads %0d required 0", read160); end
    if (op_ready !== 1'b1) begin errors++; $display("FAIL ovr_idle: op_ready=%b required 1", op_ready); end
    // err must survive a following good opcode
    start_op(6'd3, 16'd0);
    n = 0;
    while (busy && n < 30) begin
      cyc();
      n++;
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b required 1", err); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    rom[80] = WAIT_FB;
    rom[81] = ENDMICRO;
    fb_busy = 1'b1;
    start_op(6'd5, 16'd7);
    cyc();
    checks++;
    if (current_microcode !== WAIT_FB || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: code=%0d busy=%b required %0d/1", current_microcode, busy, WAIT_FB);
    end
    #2;
    n_reset = 1'b0;
    #1;
    checks += 8;
    if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
    if (op_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", op_ready); end
    if (err !== 1'b0)      begin errors++; $display("FAIL mid_err: got %b required 0", err); end
    if (rep_cnt !== '0)    begin errors++; $display("FAIL mid_rep: got %0d required 0", rep_cnt); end
    if (urom_rd !== 1'b0)  begin errors++; $display("FAIL mid_rd: got %b required 0", urom_rd); end
    if (urom_addr !== '0)  begin errors++; $display("FAIL mid_addr: got %0d required 0", urom_addr); end
    if (op_done !== 1'b0)  begin errors++; $display("FAIL mid_done: got %b required 0", op_done); end
    if (current_microcode !== WAIT_CYCLE) begin errors++; $display("FAIL mid_code: got %0d required %0d", current_microcode, WAIT_CYCLE); end
    cyc();
    fb_busy = 1'b0;
    n_reset = 1'b1;
    repeat (5) begin
      cyc();
      if (op_done) done_cnt++;
    end
    checks += 3;
    if (done_cnt !== 0)    begin errors++; $display("FAIL mid_no_done: got %0d required 0", done_cnt); end
    if (op_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b required 1", op_ready); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL mid_release_busy: got %b required 0", busy); end
  endtask

  initial begin
    n_reset      = 1'b0;
    op_valid     = 1'b0;
    op_code      = '0;
    op_rep       = '0;
    mau_all_idle = 1'b1;
    mau_any_idle = 1'b1;
    fb_busy      = 1'b0;
    ldu_busy     = 1'b0;
    start_req    = 1'b1;
    dtcu_busy    = 1'b0;
    for (int i = 0; i < (1<<UADDR_W); i++) rom[i] = WAIT_CYCLE;

    test_reset();
    test_straight();
    test_back_to_back();
    test_stall();
    test_repeat();
    test_continue();
    test_overrun();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
